// File: rtl/div_issue_ctrl.sv
// Issue/retire wrapper around the iterative unsigned divide core: handles RISC-V
// DIV/DIVU/REM/REMU sign handling, divide-by-zero, signed overflow and core timeout.
//   state  | meaning
//   IDLE   | waiting for a request, req_ready high
//   RUN    | core launched, div_start held high, timeout counter running
//   RESP   | result held for writeback until resp_ready
module div_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            resp_err,
  output logic            div_start,
  output logic [XLEN-1:0] div_A,
  output logic [XLEN-1:0] div_B,
  input  logic [XLEN-1:0] div_D,
  input  logic [XLEN-1:0] div_R,
  input  logic            div_ok,
  input  logic            div_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_e;

  state_e          state_q, state_d;
  logic            rem_q, rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic signed_op, rs1_neg, rs2_neg;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    signed_op = ~req_op[0];
    rs1_neg   = signed_op & req_rs1[XLEN-1];
    rs2_neg   = signed_op & req_rs2[XLEN-1];

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rem_d     = req_op[1];
          rd_d      = req_rd;
          rs1_d     = req_rs1;
          neg_quo_d = rs1_neg ^ rs2_neg;
          neg_rem_d = rs1_neg;
          // Negating MIN_NEG wraps to itself, which is the right unsigned magnitude.
          a_d       = rs1_neg ? -req_rs1 : req_rs1;
          b_d       = rs2_neg ? -req_rs2 : req_rs2;
          err_d     = 1'b0;
          cnt_d     = '0;
          if (req_rs2 == '0) begin
            data_d  = req_op[1] ? req_rs1 : '1;
            state_d = S_RESP;
          end else if (signed_op && (req_rs1 == MIN_NEG) && (&req_rs2)) begin
            data_d  = req_op[1] ? '0 : MIN_NEG;
            state_d = S_RESP;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (div_ok) begin
          if (rem_q) data_d = neg_rem_q ? -div_R : div_R;
          else       data_d = neg_quo_q ? -div_D : div_D;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (div_err || (cnt_q == CW'(TIMEOUT - 1))) begin
          data_d  = rem_q ? rs1_q : '1;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rem_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= '0;
      rs1_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      a_q       <= a_d;
      b_q       <= b_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign div_start  = (state_q == S_RUN);
  assign div_A      = a_q;
  assign div_B      = b_q;
  assign resp_data  = data_q;
  assign resp_rd    = rd_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural stub of the divide core.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        div_start;
  logic [31:0] div_A, div_B;
  logic [31:0] div_D = '0, div_R = '0;
  logic        div_ok = 1'b0, div_err = 1'b0;

  int checks = 0;
  int errors = 0;

  // stub_mode: 0 ok, 1 err, 2 ok and err together, 3 never answers
  int          stub_mode = 0;
  int          lat = 0;
  logic [31:0] cap_a = '0, cap_b = '0;
  logic        start_seen = 1'b0;

  div_issue_ctrl #(.XLEN(32), .TIMEOUT(256)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .div_start(div_start), .div_A(div_A), .div_B(div_B),
    .div_D(div_D), .div_R(div_R), .div_ok(div_ok), .div_err(div_err)
  );

  always #5 clk = ~clk;

  // Core stub: answers on the 5th edge that sees div_start high.
  always @(posedge clk) begin
    if (div_start) begin
      if (lat == 0) begin
        cap_a <= div_A;
        cap_b <= div_B;
      end
      if (lat == 4 && stub_mode != 3) begin
        div_ok  <= (stub_mode == 0 || stub_mode == 2);
        div_err <= (stub_mode == 1 || stub_mode == 2);
        div_D   <= (div_B != 0) ? div_A / div_B : 32'hDEAD_BEEF;
        div_R   <= (div_B != 0) ? div_A % div_B : 32'hDEAD_BEEF;
      end else begin
        div_ok  <= 1'b0;
        div_err <= 1'b0;
      end
      lat <= lat + 1;
    end else begin
      lat     <= 0;
      div_ok  <= 1'b0;
      div_err <= 1'b0;
    end
  end

  always @(posedge clk) if (div_start) start_seen = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // exp_lat 0 means the request must bypass the core.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                        input logic [31:0] exp_a, input logic [31:0] exp_b, input int hold);
    int n;
    logic [31:0] d0;
    @(negedge clk);
    check_val({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
    start_seen = 1'b0;
    req_valid = 1'b1; req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (exp_lat == 0) begin
      check_val({tag, " bypass valid"}, {31'b0, resp_valid}, 32'd1);
    end else begin
      check_val({tag, " start"}, {31'b0, div_start}, 32'd1);
      n = 0;
      while (!resp_valid && n < 600) begin
        @(posedge clk); #1;
        n++;
      end
      check_val({tag, " latency"}, n, exp_lat);
      if (exp_lat != 256) begin
        check_val({tag, " div_A"}, cap_a, exp_a);
        check_val({tag, " div_B"}, cap_b, exp_b);
      end
    end
    check_val({tag, " data"}, resp_data, exp_d);
    check_val({tag, " rd"}, {27'b0, resp_rd}, {27'b0, rd});
    check_val({tag, " err"}, {31'b0, resp_err}, {31'b0, exp_e});
    d0 = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val({tag, " hold valid"}, {31'b0, resp_valid}, 32'd1);
      check_val({tag, " hold data"}, resp_data, d0);
      check_val({tag, " hold rd"}, {27'b0, resp_rd}, {27'b0, rd});
      check_val({tag, " hold req_ready"}, {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_val({tag, " done valid"}, {31'b0, resp_valid}, 32'd0);
    check_val({tag, " done ready"}, {31'b0, req_ready}, 32'd1);
    if (exp_lat == 0)
      check_val({tag, " core untouched"}, {31'b0, start_seen}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst req_ready", {31'b0, req_ready}, 32'd1);
    check_val("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check_val("rst div_start", {31'b0, div_start}, 32'd0);
    check_val("rst resp_err", {31'b0, resp_err}, 32'd0);
    check_val("rst resp_data", resp_data, 32'd0);
    check_val("rst resp_rd", {27'b0, resp_rd}, 32'd0);
    check_val("rst div_A", div_A, 32'd0);
    check_val("rst div_B", div_B, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_req("divu",     2'b01, 32'd1023,      32'd50,        5'd1, 32'd20,        1'b0, 6, 32'd1023, 32'd50, 0);
    do_req("remu",     2'b11, 32'd1023,      32'd50,        5'd2, 32'd23,        1'b0, 6, 32'd1023, 32'd50, 0);
    do_req("div n/p",  2'b00, 32'hFFFF_FC01, 32'd50,        5'd3, 32'hFFFF_FFEC, 1'b0, 6, 32'd1023, 32'd50, 0);
    do_req("rem n/p",  2'b10, 32'hFFFF_FC01, 32'd50,        5'd4, 32'hFFFF_FFE9, 1'b0, 6, 32'd1023, 32'd50, 0);
    do_req("div p/n",  2'b00, 32'd1023,      32'hFFFF_FFCE, 5'd5, 32'hFFFF_FFEC, 1'b0, 6, 32'd1023, 32'd50, 0);
    do_req("rem p/n",  2'b10, 32'd1023,      32'hFFFF_FFCE, 5'd6, 32'd23,        1'b0, 6, 32'd1023, 32'd50, 5);
    do_req("div by0",  2'b00, 32'd7,         32'd0,         5'd7, 32'hFFFF_FFFF, 1'b0, 0, 32'd0, 32'd0, 0);
    do_req("remu by0", 2'b11, 32'd7,         32'd0,         5'd8, 32'd7,         1'b0, 0, 32'd0, 32'd0, 0);
    do_req("div ovf",  2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1'b0, 0, 32'd0, 32'd0, 0);
    do_req("rem ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,        1'b0, 0, 32'd0, 32'd0, 0);
    do_req("divu big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,        1'b0, 6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_req("div min",  2'b00, 32'h8000_0000, 32'd2,        5'd12, 32'hC000_0000, 1'b0, 6, 32'h8000_0000, 32'd2, 0);

    stub_mode = 1;
    do_req("core err", 2'b11, 32'd9,         32'd4,         5'd13, 32'd9,        1'b1, 6, 32'd9, 32'd4, 0);
    stub_mode = 2;
    do_req("ok wins",  2'b11, 32'd9,         32'd4,         5'd14, 32'd1,        1'b0, 6, 32'd9, 32'd4, 0);
    stub_mode = 3;
    do_req("timeout",  2'b01, 32'd100,       32'd7,         5'd15, 32'hFFFF_FFFF, 1'b1, 256, 32'd0, 32'd0, 0);
    stub_mode = 0;

    // Reset in the middle of a core run.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd1023; req_rs2 = 32'd50; req_rd = 5'd16;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_val("mid run start", {31'b0, div_start}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("mid rst req_ready", {31'b0, req_ready}, 32'd1);
    check_val("mid rst div_start", {31'b0, div_start}, 32'd0);
    check_val("mid rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check_val("mid rst resp_data", resp_data, 32'd0);
    check_val("mid rst div_A", div_A, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      logic stale;
      stale = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (resp_valid || div_start) stale = 1'b1;
      end
      check_val("no stale resp", {31'b0, stale}, 32'd0);
    end

    do_req("post rst", 2'b01, 32'd1023,      32'd50,        5'd17, 32'd20,       1'b0, 6, 32'd1023, 32'd50, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

RISC-V M-extension divide front/back-end that sits directly around the iterative unsigned `Divide` core. It accepts DIV/DIVU/REM/REMU requests from the execute stage and resolves divide-by-zero and signed overflow without launching the core. For all other operands it converts them to magnitudes, drives the core's `start`/`A`/`B`, waits for `ok`/`err`, and applies sign correction. It then presents the architectural result to writeback over a valid/ready handshake.

## Interface
- `XLEN`, 32, operand/result width.
- `TIMEOUT`, 256, max cycles in RUN before abort; must be ≥ 2·XLEN.

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high iff state is IDLE.
- `req_op`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `req_rs1`  in  XLEN  dividend.
- `req_rs2`  in  XLEN  divisor.
- `req_rd`  in  5  destination tag, returned unchanged.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  writeback accepts.
- `resp_data`  out  XLEN  quotient or remainder.
- `resp_rd`  out  5  tag of the request.
- `resp_err`  out  1  core reported `err` or timeout.
- `div_start`  out  1  to core `start`.
- `div_A`, `div_B`  out  XLEN  to core `A`/`B` (unsigned magnitudes).
- `div_D`, `div_R`  in  XLEN  core quotient/remainder.
- `div_ok`, `div_err`  in  1  core completion/error.

## Operation
- States: IDLE, RUN, RESP.
- **IDLE**
  - Accept on `req_valid && req_ready`.
  - Register the following:
    - op, rd, rs1.
    - `neg_q = signed & (rs1[XLEN-1] ^ rs2[XLEN-1])`.
    - `neg_r = signed & rs1[XLEN-1]`.
    - `div_A`/`div_B` = two's-complement magnitude if signed and negative, else raw.
  - Special cases go directly to RESP without touching the core:
    - Divisor zero: quotient = all ones, remainder = rs1.
    - Signed overflow (rs1 = 0x8000_0000, rs2 = all ones, op DIV/REM): quotient = 0x8000_0000, remainder = 0.
  - Otherwise go to RUN and clear the timeout counter.
- **RUN**
  - `div_start` = 1 continuously.
  - `div_A`/`div_B` held stable.
  - Counter increments each cycle.
- **RUN exits**
  - First cycle with `div_ok` = 1: `resp_data` = ops 00/01 → `neg_q ? -div_D : div_D`; ops 10/11 → `neg_r ? -div_R : div_R`. Go to RESP with `resp_err` = 0.
  - `div_err` = 1 or counter = TIMEOUT−1: `resp_data` = divide-by-zero value (all ones / rs1), `resp_err` = 1, go to RESP.
  - If `div_ok` and `div_err` rise in the same cycle, `div_ok` wins.
- **RESP**
  - `resp_valid` = 1 and `div_start` = 0.
  - `resp_data`/`resp_rd`/`resp_err` held until `resp_ready`; then go to IDLE.
- `div_start` is low in IDLE and RESP. This guarantees ≥ 2 low cycles between core launches, so the core re-arms.
- Negation is modulo 2^XLEN; magnitude of 0x8000_0000 is 0x8000_0000 unsigned (correct for core).

## Timing
- Reset (sync) forces IDLE from any state, including mid-RUN. It takes effect on the next edge.
- Outputs after reset:
  - `req_ready` = 1.
  - `resp_valid` = 0, `div_start` = 0, `resp_err` = 0.
  - `resp_data` = 0, `resp_rd` = 0, `div_A`/`div_B` = 0.
- A core result in flight at reset is discarded.
- Accept at edge N:
  - Special case: `resp_valid` high from N+1.
  - Normal: `div_start` high from N+1. If `div_ok` is first sampled high at edge M, `resp_valid` is high from M+1.
- Total latency = core latency + 2 cycles.
- No request accepted while RUN/RESP (`req_ready` = 0). Exactly one outstanding op.
- `resp_valid` never drops without `resp_ready`. Back-to-back: accept possible the cycle after a RESP handshake.

## Test plan
- DIVU 1023/50, then REMU 1023/50 → `resp_data` 20, then 23. `div_A` = 1023 and `div_B` = 50 while `div_start` = 1. `resp_err` = 0.
- DIV −1023/50 → 0xFFFF_FFEC; REM −1023/50 → 0xFFFF_FFE9; DIV 1023/−50 → 0xFFFF_FFEC; REM 1023/−50 → 23.
- DIV 7/0 → 0xFFFF_FFFF and REMU 7/0 → 7. Each has `resp_valid` one cycle after accept, and `div_start` is never asserted.
- DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000; REM → 0. Both bypass the core.
- Hold `resp_ready` low 5 cycles in RESP → `resp_data`/`resp_rd` stable and `req_ready` = 0. Then handshake, and a new request is accepted the next cycle.
- Stub core never asserts `ok` → `resp_err` = 1 after TIMEOUT cycles in RUN. Separately, assert `reset` for 1 cycle mid-RUN → next cycle IDLE, `div_start` = 0, `resp_valid` = 0, and no stale response.
